spi_master_mc: RTL and testbench
================================

# spi_master_mc

Parametrised SPI master, the successor to the single-slave `spi_drv`. It runs from the system clock, derives SCLK internally, and supports all four CPOL/CPHA modes. It drives one of `NUM_SS` chip selects per transaction and moves 1..`SPI_MAXLEN` bits full-duplex. It sits between a register-level command source (CPU bridge or sequencer) and the external SPI pins.

## Interface
- `CLK_DIVIDE`, 100: clk cycles per SCLK half-period; must be ≥1 (elaboration assertion).
- `SPI_MAXLEN`, 16: maximum bits per transaction.
- `NUM_SS`, 4: number of chip-select outputs; must be ≥1.

- `clk` in 1: system clock; all logic is on its rising edge.
- `sreset` in 1: synchronous, active-high reset.
- `start_cmd` in 1: transaction request; accepted only while `spi_drv_rdy`=1.
- `spi_drv_rdy` out 1: idle and able to accept a request.
- `n_clks` in $clog2(SPI_MAXLEN)+1: bit count for the transaction.
- `cpol` in 1: SCLK idle level.
- `cpha` in 1: 0 = sample on leading edge; 1 = sample on trailing edge.
- `ss_sel` in max(1,$clog2(NUM_SS)): index of the chip select to assert.
- `tx_data` in SPI_MAXLEN: transmit word, right-aligned.
- `rx_miso` out SPI_MAXLEN: received word, right-aligned, upper bits zero.
- `rx_valid` out 1: one-cycle pulse when `rx_miso` is updated.
- `SCLK` out 1, `MOSI` out 1, `MISO` in 1: SPI pins.
- `SS_N` out NUM_SS: active-low chip selects.

## Operation
- A request is accepted on a cycle with `start_cmd`=1 and `spi_drv_rdy`=1. On acceptance, `n_clks`, `tx_data`, `cpol`, `cpha` and `ss_sel` are latched. Inputs are don't-care afterwards.
- `n_clks`=0: the request is ignored and `spi_drv_rdy` stays 1. `n_clks`>SPI_MAXLEN: clamped to SPI_MAXLEN.
- `ss_sel`≥NUM_SS: the transaction runs with all `SS_N` high (dummy clocks).
- FSM states:
  - IDLE: on accept, go to SETUP.
  - SETUP: CLK_DIVIDE cycles, then SHIFT.
  - SHIFT: 2·n SCLK edges, then HOLD.
  - HOLD: CLK_DIVIDE cycles, then IDLE.
- Bit order is MSB-first: bit n-1 of the latched `tx_data` is sent first. Received bits shift into the LSB.
- CPHA=0: MOSI is valid from SS assertion. Sample on each leading edge; shift MOSI on each trailing edge except the last.
- CPHA=1: shift MOSI on each leading edge; sample on each trailing edge.
- SCLK idles at the latched `cpol` during SETUP and HOLD. It is held at its last IDLE level until the next accept, then takes the new `cpol` in SETUP.
- In HOLD→IDLE, the shift register is copied to `rx_miso` and `rx_valid` pulses.

## Timing
- Reset values: `spi_drv_rdy`=1, `SS_N`=all 1, `SCLK`=0, `MOSI`=0, `rx_miso`=0, `rx_valid`=0, FSM=IDLE.
- Let accept be at cycle T0 and D=CLK_DIVIDE.
  - T0+1: `SS_N[ss_sel]`=0, `spi_drv_rdy`=0, `SCLK`=cpol.
  - Leading edge k (k=0..n-1): T0+1+D·(2k+1).
  - Trailing edge k: T0+1+D·(2k+2).
  - T0+1+D·(2n+1): `SS_N` all 1, `spi_drv_rdy`=1, `rx_valid`=1 for one cycle, `rx_miso` valid and held until the next `rx_valid`.
- Back-to-back: if `start_cmd` is high in the `rx_valid` cycle, the next transaction is accepted. `SS_N` is then high for exactly one cycle.
- `sreset` mid-transaction: all outputs take their reset values on the next edge. No `rx_valid` pulse is generated.
- `start_cmd` while busy is ignored, not queued.

## Configuration
- `SPI_MASTER_LOOPBACK_EN` defined: adds input port `loopback` (1 bit), sampled at accept. When it is 1, the sampler uses internal MOSI instead of `MISO`. Pin outputs are unchanged.
- Not defined: the `loopback` port is absent and `MISO` is always sampled.

## Structure
- Package `spi_pkg`:
  - `spi_state_t` enum (IDLE, SETUP, SHIFT, HOLD).
  - `spi_mode_t` packed struct {cpol, cpha}.
  - Helper function for the clamp of `n_clks`.
- Sub-module `spi_clk_gen`:
  - D-cycle divider with enable.
  - Outputs one-cycle `lead_stb` and `trail_stb` strobes and the SCLK level.
- Top level holds the FSM, bit counter, and shift registers.

## Test plan
- Mode 0, D=2, n=8, tx=0xD1, slave echoes 0xA5 → MOSI bits 1,1,0,1,0,0,0,1; `rx_miso`=0x00A5; `rx_valid` at T0+35; only `SS_N[0]` low.
- Modes 1/2/3 with n=10, tx=0x2C3, ss_sel=2 → correct SCLK idle level and sample edge for each mode; `rx_miso` matches the slave model; only `SS_N[2]` asserted.
- n_clks=0 → no SS, no SCLK, rdy stays 1. n_clks=20 → exactly 16 SCLK pulses.
- `start_cmd` held high for 3 transactions → `SS_N` high exactly 1 cycle between them; 3 `rx_valid` pulses.
- `sreset` asserted at edge 5 → next cycle: `SS_N`=all 1, SCLK=0, rdy=1, no `rx_valid`.
- With `SPI_MASTER_LOOPBACK_EN` and loopback=1, MISO tied 0, tx=0x3C5A, n=16 → `rx_miso`=0x3C5A.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the spi_master_mc SPI master.
package spi_pkg;

    // Transaction phases of the master FSM
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    // Clock mode latched at accept
    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Requested bit count limited to what the shift registers can hold
    function automatic int unsigned clamp_len(input int unsigned n, input int unsigned max_len);
        return (n > max_len) ? max_len : n;
    endfunction

endpackage

// File: rtl/spi_master_mc_clk_gen.sv
// spi_clk_gen: CLK_DIVIDE-cycle divider that paces SCLK edges and owns the SCLK flop.
// The divider runs while en is high; tick marks the last cycle of each half-period.
// SCLK toggles on a tick only while sclk_en is high, reporting the edge as lead/trail.
module spi_clk_gen #(
    parameter int unsigned CLK_DIVIDE = 100
) (
    input  logic clk,
    input  logic sreset,
    input  logic en,
    input  logic sclk_en,
    input  logic load,
    input  logic load_level,
    output logic tick,
    output logic lead_stb,
    output logic trail_stb,
    output logic sclk
);
    import spi_pkg::*;

    localparam int unsigned CNT_W = (CLK_DIVIDE > 1) ? $clog2(CLK_DIVIDE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIVIDE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;  // 1 after a leading edge, 0 after a trailing edge
    logic             sclk_q, sclk_d;

    // Divider count, edge strobes and next SCLK level
    always_comb begin
        tick      = en && (cnt_q == CNT_MAX);
        lead_stb  = tick && sclk_en && !phase_q;
        trail_stb = tick && sclk_en && phase_q;
        cnt_d     = (!en || tick) ? '0 : cnt_q + 1'b1;
        phase_d   = phase_q;
        sclk_d    = sclk_q;
        if (load) begin
            phase_d = 1'b0;
            sclk_d  = load_level;
        end else if (lead_stb || trail_stb) begin
            phase_d = ~phase_q;
            sclk_d  = ~sclk_q;
        end
    end

    // Divider and SCLK state
    always_ff @(posedge clk) begin
        if (sreset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            sclk_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            sclk_q  <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-chip-select SPI master, all four CPOL/CPHA modes, 1..SPI_MAXLEN bits.
// Optional feature macro SPI_MASTER_LOOPBACK_EN adds a loopback input that makes the
// sampler read the internal MOSI instead of the MISO pin.
module spi_master_mc #(
    parameter int unsigned CLK_DIVIDE = 100,
    parameter int unsigned SPI_MAXLEN = 16,
    parameter int unsigned NUM_SS     = 4,
    localparam int unsigned LEN_W     = $clog2(SPI_MAXLEN) + 1,
    localparam int unsigned SS_W      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                  clk,
    input  logic                  sreset,
    input  logic                  start_cmd,
    output logic                  spi_drv_rdy,
    input  logic [LEN_W-1:0]      n_clks,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [SS_W-1:0]       ss_sel,
    input  logic [SPI_MAXLEN-1:0] tx_data,
    output logic [SPI_MAXLEN-1:0] rx_miso,
    output logic                  rx_valid,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                  loopback,
`endif
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic [NUM_SS-1:0]     SS_N
);
    import spi_pkg::*;

    if (CLK_DIVIDE < 1) begin : g_bad_divide
        $error("CLK_DIVIDE must be at least 1");
    end
    if (NUM_SS < 1) begin : g_bad_num_ss
        $error("NUM_SS must be at least 1");
    end

    spi_state_t            state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    spi_mode_t             mode_q, mode_d;
    logic [SS_W-1:0]       ss_q, ss_d;
    logic [LEN_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [SPI_MAXLEN-1:0] tx_sr_q, tx_sr_d;
    logic [SPI_MAXLEN-1:0] rx_sr_q, rx_sr_d;
    logic                  mosi_q, mosi_d;
    logic [SPI_MAXLEN-1:0] rx_miso_q, rx_miso_d;
    logic                  rx_valid_q, rx_valid_d;

    logic                  accept;
    logic [LEN_W-1:0]      n_eff;
    logic [SPI_MAXLEN-1:0] tx_align;
    logic                  last_bit;
    logic                  sample_stb;
    logic                  shift_stb;
    logic                  sample_bit;
    logic                  tick;
    logic                  lead_stb;
    logic                  trail_stb;

    // Request qualification; a zero-length request is dropped while staying ready
    always_comb begin
        n_eff    = LEN_W'(clamp_len(32'(n_clks), SPI_MAXLEN));
        accept   = (state_q == IDLE) && start_cmd && (n_clks != '0);
        // MSB of the n-bit word moved to the top so it always leaves first
        tx_align = tx_data << (LEN_W'(SPI_MAXLEN) - n_eff);
        last_bit = (bit_cnt_q == len_q - 1'b1);
    end

`ifdef SPI_MASTER_LOOPBACK_EN
    logic lb_q, lb_d;

    // Loopback selection, latched at accept like the other transaction settings
    always_comb begin
        lb_d       = accept ? loopback : lb_q;
        sample_bit = lb_q ? mosi_q : MISO;
    end

    // Loopback flag register
    always_ff @(posedge clk) begin
        if (sreset) lb_q <= 1'b0;
        else        lb_q <= lb_d;
    end
`else
    assign sample_bit = MISO;
`endif

    spi_clk_gen #(
        .CLK_DIVIDE(CLK_DIVIDE)
    ) u_clk_gen (
        .clk       (clk),
        .sreset    (sreset),
        .en        (state_q != IDLE),
        .sclk_en   ((state_q == SETUP) || (state_q == SHIFT)),
        .load      (accept),
        .load_level(cpol),
        .tick      (tick),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .sclk      (SCLK)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (sreset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; the SETUP tick is also leading edge 0
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   if (tick) state_d = SHIFT;
            SHIFT:   if (trail_stb && last_bit) state_d = HOLD;
            HOLD:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        spi_drv_rdy = (state_q == IDLE);
        SS_N        = '1;
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            if ((state_q != IDLE) && (32'(ss_q) == i)) SS_N[i] = 1'b0;
        end
        MOSI     = mosi_q;
        rx_miso  = rx_miso_q;
        rx_valid = rx_valid_q;
    end

    // Datapath next state: latch at accept, shift on the mode's edges, publish in HOLD
    always_comb begin
        sample_stb = mode_q.cpha ? trail_stb : lead_stb;
        // With CPHA=0 the first bit is already on MOSI, so the final trailing edge is idle
        shift_stb  = mode_q.cpha ? lead_stb : (trail_stb && !last_bit);
        len_d      = len_q;
        mode_d     = mode_q;
        ss_d       = ss_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        mosi_d     = mosi_q;
        rx_miso_d  = rx_miso_q;
        rx_valid_d = 1'b0;
        if (accept) begin
            len_d     = n_eff;
            mode_d    = '{cpol: cpol, cpha: cpha};
            ss_d      = ss_sel;
            bit_cnt_d = '0;
            rx_sr_d   = '0;
            if (!cpha) begin
                mosi_d  = tx_align[SPI_MAXLEN-1];
                tx_sr_d = tx_align << 1;
            end else begin
                tx_sr_d = tx_align;
            end
        end else begin
            if (sample_stb) rx_sr_d = (rx_sr_q << 1) | SPI_MAXLEN'(sample_bit);
            if (shift_stb) begin
                mosi_d  = tx_sr_q[SPI_MAXLEN-1];
                tx_sr_d = tx_sr_q << 1;
            end
            if (trail_stb) bit_cnt_d = bit_cnt_q + 1'b1;
            if ((state_q == HOLD) && tick) begin
                rx_miso_d  = rx_sr_q;
                rx_valid_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (sreset) begin
            len_q      <= '0;
            mode_q     <= '0;
            ss_q       <= '0;
            bit_cnt_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            mosi_q     <= 1'b0;
            rx_miso_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            len_q      <= len_d;
            mode_q     <= mode_d;
            ss_q       <= ss_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            mosi_q     <= mosi_d;
            rx_miso_q  <= rx_miso_d;
            rx_valid_q <= rx_valid_d;
        end
    end

endmodule

// File: tb/tb_spi_master_mc.sv
// tb_spi_master_mc: self-checking bench for spi_master_mc (D=2, 16-bit, 3 chip selects).
module tb_spi_master_mc;
    localparam int unsigned D      = 2;
    localparam int unsigned MAXLEN = 16;
    localparam int unsigned NSS    = 3;
    localparam int unsigned LEN_W  = $clog2(MAXLEN) + 1;
    localparam int unsigned SS_W   = 2;

    logic              clk = 1'b0;
    logic              sreset;
    logic              start_cmd;
    logic              spi_drv_rdy;
    logic [LEN_W-1:0]  n_clks;
    logic              cpol;
    logic              cpha;
    logic [SS_W-1:0]   ss_sel;
    logic [MAXLEN-1:0] tx_data;
    logic [MAXLEN-1:0] rx_miso;
    logic              rx_valid;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;
    logic [NSS-1:0]    SS_N;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic              loopback;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_master_mc #(
        .CLK_DIVIDE(D),
        .SPI_MAXLEN(MAXLEN),
        .NUM_SS    (NSS)
    ) dut (
        .clk        (clk),
        .sreset     (sreset),
        .start_cmd  (start_cmd),
        .spi_drv_rdy(spi_drv_rdy),
        .n_clks     (n_clks),
        .cpol       (cpol),
        .cpha       (cpha),
        .ss_sel     (ss_sel),
        .tx_data    (tx_data),
        .rx_miso    (rx_miso),
        .rx_valid   (rx_valid),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback   (loopback),
`endif
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .SS_N       (SS_N)
    );

    typedef struct {
        int unsigned n;
        logic [15:0] tx;
        logic [15:0] sw;      // word the slave model sends back
        logic        cpol;
        logic        cpha;
        int unsigned ss;
        logic        lb;
        logic [15:0] exp_rx;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int unsigned n, input logic [15:0] tx, input logic [15:0] sw,
                                input logic pol, input logic pha, input int unsigned ss,
                                input logic lb, input logic [15:0] exp_rx);
        vec_t v;
        v.n = n; v.tx = tx; v.sw = sw; v.cpol = pol; v.cpha = pha;
        v.ss = ss; v.lb = lb; v.exp_rx = exp_rx;
        return v;
    endfunction

    // Reference expectation: the slave's (or looped-back) low n bits, n clamped to MAXLEN
    function automatic logic [15:0] model_rx(input vec_t v);
        int unsigned ne;
        logic [15:0] mask;
        ne   = (v.n > MAXLEN) ? MAXLEN : v.n;
        mask = (ne >= 16) ? 16'hFFFF : 16'((32'd1 << ne) - 1);
        return (v.lb ? v.tx : v.sw) & mask;
    endfunction

    // One transaction with an SPI slave model driven from the observed SCLK edges
    task automatic run_txn(input vec_t v, input string name);
        int unsigned ne;
        logic [15:0] mask;
        logic [15:0] got_mosi;
        logic [NSS-1:0] exp_ss;
        int off, toggles, leads, idx, limit;
        bit ss_bad, tim_bad, done;
        logic prev;
        logic [15:0] rx_seen;
        ne     = (v.n > MAXLEN) ? MAXLEN : v.n;
        mask   = (ne >= 16) ? 16'hFFFF : 16'((32'd1 << ne) - 1);
        exp_ss = '1;
        if (v.ss < NSS) exp_ss[v.ss] = 1'b0;
        got_mosi = '0; toggles = 0; leads = 0; ss_bad = 0; tim_bad = 0; done = 0;
        limit = 1 + int'(D) * (2 * int'(ne) + 1) + 10;

        @(negedge clk);
        n_clks    = LEN_W'(v.n);
        tx_data   = v.tx;
        cpol      = v.cpol;
        cpha      = v.cpha;
        ss_sel    = SS_W'(v.ss);
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback  = v.lb;
`endif
        MISO      = 1'b0;
        start_cmd = 1'b1;
        @(negedge clk);
        start_cmd = 1'b0;
        off = 1;
        chk({name, " rdy_low"}, 32'(spi_drv_rdy), 32'd0);
        chk({name, " sclk_idle"}, 32'(SCLK), 32'(v.cpol));
        chk({name, " ss_assert"}, 32'(SS_N), 32'(exp_ss));
        idx = int'(ne) - 1;
        if (!v.cpha) MISO = v.sw[idx];
        prev = SCLK;

        while (!done && off < limit) begin
            @(negedge clk);
            off++;
            if (rx_valid === 1'b1) begin
                done = 1;
            end else begin
                if (SS_N !== exp_ss) ss_bad = 1;
                if (SCLK !== prev) begin
                    toggles++;
                    if (off != 1 + int'(D) * toggles) tim_bad = 1;
                    if (prev == v.cpol) begin
                        leads++;
                        if (!v.cpha) got_mosi = {got_mosi[14:0], MOSI};
                        else if (idx >= 0) begin
                            MISO = v.sw[idx];
                            idx--;
                        end
                    end else begin
                        if (v.cpha) got_mosi = {got_mosi[14:0], MOSI};
                        else begin
                            idx--;
                            if (idx >= 0) MISO = v.sw[idx];
                        end
                    end
                    prev = SCLK;
                end
            end
        end

        chk({name, " rx_valid_seen"}, 32'(done), 32'd1);
        chk({name, " latency"}, 32'(off), 32'(1 + int'(D) * (2 * int'(ne) + 1)));
        chk({name, " rx_miso"}, 32'(rx_miso), 32'(v.exp_rx));
        chk({name, " sclk_edges"}, 32'(toggles), 32'(2 * ne));
        chk({name, " lead_edges"}, 32'(leads), 32'(ne));
        chk({name, " mosi_bits"}, 32'(got_mosi), 32'(v.tx & mask));
        chk({name, " edge_timing_ok"}, 32'(tim_bad), 32'd0);
        chk({name, " ss_stable"}, 32'(ss_bad), 32'd0);
        chk({name, " ss_release"}, 32'(SS_N), 32'((1 << NSS) - 1));
        chk({name, " rdy_back"}, 32'(spi_drv_rdy), 32'd1);
        rx_seen = rx_miso;
        @(negedge clk);
        chk({name, " rx_valid_pulse"}, 32'(rx_valid), 32'd0);
        chk({name, " rx_miso_held"}, 32'(rx_miso), 32'(rx_seen));
    endtask

    initial begin
        vec_t v;
        int pulses, gaps, run, bad;
        bit gap_bad, rxbad, seen_low;
        logic prev;

        sreset = 1'b1; start_cmd = 1'b0; n_clks = '0; cpol = 1'b0; cpha = 1'b0;
        ss_sel = '0; tx_data = '0; MISO = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = 1'b0;
`endif
        repeat (3) @(negedge clk);
        sreset = 1'b0;
        chk("reset rdy", 32'(spi_drv_rdy), 32'd1);
        chk("reset ss_n", 32'(SS_N), 32'h7);
        chk("reset sclk", 32'(SCLK), 32'd0);
        chk("reset mosi", 32'(MOSI), 32'd0);
        chk("reset rx_miso", 32'(rx_miso), 32'd0);
        chk("reset rx_valid", 32'(rx_valid), 32'd0);

        // Directed vectors: n, tx, slave word, cpol, cpha, ss, loopback, expected rx
        vecs.push_back(mk(8, 16'h00D1, 16'h00A5, 1'b0, 1'b0, 0, 1'b0, 16'h00A5));
        vecs.push_back(mk(10, 16'h02C3, 16'h015A, 1'b0, 1'b1, 2, 1'b0, 16'h015A));
        vecs.push_back(mk(10, 16'h02C3, 16'h015A, 1'b1, 1'b0, 2, 1'b0, 16'h015A));
        vecs.push_back(mk(10, 16'h02C3, 16'h015A, 1'b1, 1'b1, 2, 1'b0, 16'h015A));
        vecs.push_back(mk(20, 16'hF00F, 16'hBEEF, 1'b0, 1'b0, 1, 1'b0, 16'hBEEF));
        vecs.push_back(mk(1, 16'h0001, 16'h0001, 1'b1, 1'b1, 0, 1'b0, 16'h0001));
        vecs.push_back(mk(16, 16'h1234, 16'h8001, 1'b1, 1'b0, 3, 1'b0, 16'h8001));
        vecs.push_back(mk(5, 16'hFFE0, 16'hFFFF, 1'b0, 1'b1, 1, 1'b0, 16'h001F));
`ifdef SPI_MASTER_LOOPBACK_EN
        vecs.push_back(mk(16, 16'h3C5A, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 16'h3C5A));
`endif
        foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Randomised transactions against the reference model
        for (int i = 0; i < 20; i++) begin
            v = mk($urandom_range(1, 20), 16'($urandom), 16'($urandom), 1'($urandom),
                   1'($urandom), $urandom_range(0, 3), 1'b0, 16'h0);
`ifdef SPI_MASTER_LOOPBACK_EN
            v.lb = 1'($urandom);
`endif
            v.exp_rx = model_rx(v);
            run_txn(v, $sformatf("rnd%0d", i));
        end

        // Zero-length request is ignored
        @(negedge clk);
        n_clks = '0; start_cmd = 1'b1; ss_sel = 2'd0; cpol = ~SCLK;
        prev = SCLK; bad = 0;
        repeat (4 * D + 4) begin
            @(negedge clk);
            if (spi_drv_rdy !== 1'b1 || SS_N !== 3'b111 || SCLK !== prev) bad++;
        end
        start_cmd = 1'b0;
        chk("zero_len quiet", 32'(bad), 32'd0);

        // start_cmd held: three back-to-back transactions
        @(negedge clk);
        n_clks = LEN_W'(4); tx_data = 16'h000A; cpol = 1'b0; cpha = 1'b0; ss_sel = 2'd1;
        MISO = 1'b1; start_cmd = 1'b1;
        pulses = 0; gaps = 0; run = 0; gap_bad = 0; rxbad = 0; seen_low = 0;
        for (int c = 0; c < 400 && pulses < 3; c++) begin
            @(negedge clk);
            if (SS_N !== 3'b111) begin
                if (seen_low && run > 0) begin
                    gaps++;
                    if (run != 1) gap_bad = 1;
                end
                seen_low = 1;
                run = 0;
            end else if (seen_low) begin
                run++;
            end
            if (rx_valid === 1'b1) begin
                pulses++;
                if (rx_miso !== 16'h000F) rxbad = 1;
                if (pulses == 3) start_cmd = 1'b0;
            end
        end
        chk("b2b pulses", 32'(pulses), 32'd3);
        chk("b2b gaps", 32'(gaps), 32'd2);
        chk("b2b gap_one_cycle", 32'(gap_bad), 32'd0);
        chk("b2b rx_miso", 32'(rxbad), 32'd0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (spi_drv_rdy !== 1'b1 || rx_valid !== 1'b0) bad++;
        end
        chk("b2b no_fourth", 32'(bad), 32'd0);

        // Synchronous reset after the fifth SCLK edge
        @(negedge clk);
        n_clks = LEN_W'(8); tx_data = 16'h00FF; cpol = 1'b1; cpha = 1'b0; ss_sel = 2'd0;
        MISO = 1'b1; start_cmd = 1'b1;
        @(negedge clk);
        start_cmd = 1'b0;
        prev = SCLK; run = 0;
        for (int c = 0; c < 100 && run < 5; c++) begin
            @(negedge clk);
            if (SCLK !== prev) begin
                run++;
                prev = SCLK;
            end
        end
        chk("rst edges_reached", 32'(run), 32'd5);
        sreset = 1'b1;
        @(negedge clk);
        sreset = 1'b0;
        chk("rst ss_n", 32'(SS_N), 32'h7);
        chk("rst sclk", 32'(SCLK), 32'd0);
        chk("rst rdy", 32'(spi_drv_rdy), 32'd1);
        chk("rst mosi", 32'(MOSI), 32'd0);
        chk("rst rx_miso", 32'(rx_miso), 32'd0);
        bad = 0;
        repeat (40) begin
            if (rx_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("rst no_rx_valid", 32'(bad), 32'd0);

        // Recovery after reset
        run_txn(vecs[0], "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
